// File: rtl/riscv_v_logic_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_v_logic_seq                                                          |
// | Sequencer for the vector logic/shift ALU: streams LMUL-group beats through |
// | the ALU and folds reduction partials into a single masked result.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module riscv_v_logic_seq #(
    parameter int DATA_W  = 128,
    parameter int NREGS_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic                cmd_reduct,
    input  logic                cmd_neg_a,
    input  logic                cmd_neg_res,
    input  logic [2:0]          cmd_osize,
    input  logic [NREGS_W-1:0]  cmd_nregs,
    input  logic                beat_valid,
    output logic                beat_ready,
    input  logic [DATA_W-1:0]   beat_srca,
    input  logic [DATA_W-1:0]   beat_srcb,
    output logic                alu_is_and,
    output logic                alu_is_or,
    output logic                alu_is_xor,
    output logic                alu_is_shift,
    output logic                alu_is_left,
    output logic                alu_is_arith,
    output logic                alu_is_reduct,
    output logic                alu_is_negate_srca,
    output logic                alu_is_negate_result,
    output logic [4:0]          alu_osize_vector,
    output logic [4:0]          alu_is_greater_osize_vector,
    output logic [DATA_W-1:0]   alu_srca,
    output logic [DATA_W-1:0]   alu_srcb,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_data,
    output logic                res_last,
    output logic                busy,
    output logic                cmd_err
);

    localparam logic [2:0] C_OP_AND  = 3'd0;
    localparam logic [2:0] C_OP_OR   = 3'd1;
    localparam logic [2:0] C_OP_XOR  = 3'd2;
    localparam logic [2:0] C_OP_SLL  = 3'd3;
    localparam logic [2:0] C_OP_SRL  = 3'd4;
    localparam logic [2:0] C_OP_SRA  = 3'd5;
    localparam logic [2:0] C_OSZ_MAX = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RED_OUT = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_op;
    logic                 r_reduct;
    logic                 r_neg_a;
    logic                 r_neg_res;
    logic [2:0]           r_osize;
    logic [NREGS_W-1:0]   r_cnt;
    logic                 r_first;
    logic                 r_red_loaded;
    logic [DATA_W-1:0]    r_acc;

    logic                 w_run;
    logic                 w_op_rsvd;
    logic                 w_osize_bad;
    logic                 w_cmd_is_shift;
    logic [NREGS_W-1:0]   w_nregs_eff;
    logic                 w_beat_fire;
    logic                 w_last_beat;
    logic [DATA_W-1:0]    w_acc_next;
    logic [DATA_W-1:0]    w_mask;
    logic [31:0]          w_elem_bits;
    logic [DATA_W-1:0]    w_red_out;

    assign w_run          = (r_state == S_RUN);
    assign w_op_rsvd      = (cmd_op > C_OP_SRA);
    assign w_osize_bad    = (cmd_osize > C_OSZ_MAX);
    assign w_cmd_is_shift = (cmd_op == C_OP_SLL) | (cmd_op == C_OP_SRL) | (cmd_op == C_OP_SRA);
    assign w_nregs_eff    = (cmd_nregs == '0) ? NREGS_W'(1) : cmd_nregs;
    assign w_last_beat    = (r_cnt == NREGS_W'(1));

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE) | res_valid;
    // Reductions never touch the result register while running, so they need no backpressure.
    assign beat_ready  = w_run & (r_reduct | ~res_valid | res_ready);
    assign w_beat_fire = beat_valid & beat_ready;

    assign alu_srca = beat_srca;
    assign alu_srcb = beat_srcb;

    assign alu_is_and           = w_run & (r_op == C_OP_AND);
    assign alu_is_or            = w_run & (r_op == C_OP_OR);
    assign alu_is_xor           = w_run & (r_op == C_OP_XOR);
    assign alu_is_shift         = w_run & ((r_op == C_OP_SLL) | (r_op == C_OP_SRL) | (r_op == C_OP_SRA));
    assign alu_is_left          = w_run & (r_op == C_OP_SLL);
    assign alu_is_arith         = w_run & (r_op == C_OP_SRA);
    assign alu_is_reduct        = w_run & r_reduct;
    assign alu_is_negate_srca   = w_run & r_neg_a;
    // For reductions the inversion is applied once to the folded value instead.
    assign alu_is_negate_result = w_run & r_neg_res & ~r_reduct;

    always_comb begin
        alu_osize_vector            = '0;
        alu_is_greater_osize_vector = '0;
        if (w_run) begin
            alu_osize_vector = 5'b00001 << r_osize;
        end
        for (int i = 0; i < 5; i++) begin
            alu_is_greater_osize_vector[i] = w_run && (r_osize > 3'(i));
        end
    end

    always_comb begin
        w_acc_next = alu_result;
        if (!r_first) begin
            case (r_op)
                C_OP_OR:  w_acc_next = r_acc | alu_result;
                C_OP_XOR: w_acc_next = r_acc ^ alu_result;
                default:  w_acc_next = r_acc & alu_result;
            endcase
        end
    end

    always_comb begin
        w_elem_bits = 32'd8 << r_osize;
        w_mask      = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (32'(i) < w_elem_bits);
        end
        w_red_out = (r_neg_res ? ~r_acc : r_acc) & w_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= C_OP_AND;
            r_reduct     <= 1'b0;
            r_neg_a      <= 1'b0;
            r_neg_res    <= 1'b0;
            r_osize      <= '0;
            r_cnt        <= '0;
            r_first      <= 1'b0;
            r_red_loaded <= 1'b0;
            r_acc        <= '0;
            res_valid    <= 1'b0;
            res_last     <= 1'b0;
            res_data     <= '0;
            cmd_err      <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
                res_last  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state      <= S_RUN;
                        r_op         <= w_op_rsvd ? C_OP_AND : cmd_op;
                        r_neg_a      <= w_op_rsvd ? 1'b0 : cmd_neg_a;
                        r_neg_res    <= w_op_rsvd ? 1'b0 : cmd_neg_res;
                        r_reduct     <= cmd_reduct & ~w_cmd_is_shift;
                        r_osize      <= w_osize_bad ? C_OSZ_MAX : cmd_osize;
                        r_cnt        <= w_nregs_eff;
                        r_first      <= 1'b1;
                        r_red_loaded <= 1'b0;
                        cmd_err      <= w_op_rsvd | w_osize_bad;
                    end
                end

                S_RUN: begin
                    if (w_beat_fire) begin
                        r_cnt   <= r_cnt - NREGS_W'(1);
                        r_first <= 1'b0;
                        if (r_reduct) begin
                            r_acc <= w_acc_next;
                            if (w_last_beat) begin
                                r_state <= S_RED_OUT;
                            end
                        end else begin
                            res_data  <= alu_result;
                            res_valid <= 1'b1;
                            res_last  <= w_last_beat;
                            if (w_last_beat) begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end

                S_RED_OUT: begin
                    // A result from the previous command may still occupy the output register.
                    if (!r_red_loaded) begin
                        if (!res_valid || res_ready) begin
                            res_data     <= w_red_out;
                            res_valid    <= 1'b1;
                            res_last     <= 1'b1;
                            r_red_loaded <= 1'b1;
                        end
                    end else if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_v_logic_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_v_logic_seq                                                       |
// | Directed bench for riscv_v_logic_seq with a behavioural ALU model.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_riscv_v_logic_seq;

    localparam int DW = 128;
    localparam int NW = 4;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic            cmd_reduct;
    logic            cmd_neg_a;
    logic            cmd_neg_res;
    logic [2:0]      cmd_osize;
    logic [NW-1:0]   cmd_nregs;
    logic            beat_valid;
    logic            beat_ready;
    logic [DW-1:0]   beat_srca;
    logic [DW-1:0]   beat_srcb;
    logic            alu_is_and, alu_is_or, alu_is_xor, alu_is_shift, alu_is_left;
    logic            alu_is_arith, alu_is_reduct, alu_is_negate_srca, alu_is_negate_result;
    logic [4:0]      alu_osize_vector;
    logic [4:0]      alu_is_greater_osize_vector;
    logic [DW-1:0]   alu_srca;
    logic [DW-1:0]   alu_srcb;
    logic [DW-1:0]   alu_result;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic            res_last;
    logic            busy;
    logic            cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    logic [18:0]   ctl_pack;

    riscv_v_logic_seq #(.DATA_W(DW), .NREGS_W(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_reduct(cmd_reduct), .cmd_neg_a(cmd_neg_a), .cmd_neg_res(cmd_neg_res),
        .cmd_osize(cmd_osize), .cmd_nregs(cmd_nregs),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_srca(beat_srca), .beat_srcb(beat_srcb),
        .alu_is_and(alu_is_and), .alu_is_or(alu_is_or), .alu_is_xor(alu_is_xor),
        .alu_is_shift(alu_is_shift), .alu_is_left(alu_is_left), .alu_is_arith(alu_is_arith),
        .alu_is_reduct(alu_is_reduct), .alu_is_negate_srca(alu_is_negate_srca),
        .alu_is_negate_result(alu_is_negate_result),
        .alu_osize_vector(alu_osize_vector),
        .alu_is_greater_osize_vector(alu_is_greater_osize_vector),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ctl_pack = {alu_is_and, alu_is_or, alu_is_xor, alu_is_shift, alu_is_left,
                       alu_is_arith, alu_is_reduct, alu_is_negate_srca, alu_is_negate_result,
                       alu_osize_vector, alu_is_greater_osize_vector};

    // Behavioural ALU: whole-width bitwise/shift operation; reduction lanes are not folded here.
    always_comb begin
        logic [DW-1:0] a_eff;
        a_eff = alu_is_negate_srca ? ~alu_srca : alu_srca;
        alu_result = '0;
        if (alu_is_shift) begin
            if (alu_is_left)       alu_result = alu_srca << alu_srcb[6:0];
            else if (alu_is_arith) alu_result = $unsigned($signed(alu_srca) >>> alu_srcb[6:0]);
            else                   alu_result = alu_srca >> alu_srcb[6:0];
        end else if (alu_is_and) alu_result = a_eff & alu_srcb;
        else if (alu_is_or)      alu_result = a_eff | alu_srcb;
        else if (alu_is_xor)     alu_result = a_eff ^ alu_srcb;
        if (alu_is_negate_result) alu_result = ~alu_result;
    end

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            q_data.push_back(res_data);
            q_last.push_back(res_last);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic red, input logic na, input logic nr,
                            input logic [2:0] os, input logic [NW-1:0] nregs);
        int t = 0;
        cmd_op = op; cmd_reduct = red; cmd_neg_a = na; cmd_neg_res = nr;
        cmd_osize = os; cmd_nregs = nregs; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) check("cmd_ready_wait", DW'(cmd_ready), DW'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int t = 0;
        beat_srca = a; beat_srcb = b; beat_valid = 1'b1;
        @(negedge clk);
        while (!beat_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) check("beat_ready_wait", DW'(beat_ready), DW'(1));
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic [DW-1:0] d, input logic l);
        logic [DW-1:0] gd;
        logic          gl;
        gd = 'x;
        gl = 1'bx;
        if (q_data.size() != 0) begin
            gd = q_data.pop_front();
            gl = q_last.pop_front();
        end
        check({tag, "_data"}, gd, d);
        check({tag, "_last"}, DW'(gl), DW'(l));
    endtask

    initial begin
        logic [DW-1:0] v;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_reduct = 1'b0; cmd_neg_a = 1'b0;
        cmd_neg_res = 1'b0; cmd_osize = '0; cmd_nregs = '0; beat_valid = 1'b0;
        beat_srca = '0; beat_srcb = '0; res_ready = 1'b1;
        cycles(3);

        check("rst_cmd_ready", DW'(cmd_ready), DW'(1));
        check("rst_res_valid", DW'(res_valid), DW'(0));
        check("rst_res_data",  res_data, '0);
        check("rst_busy",      DW'(busy), DW'(0));
        check("rst_alu_ctl",   DW'(ctl_pack), DW'(0));
        rst_n = 1'b1;
        cycles(1);

        // and, two beats, full throughput
        send_cmd(3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
        check("t1_busy", DW'(busy), DW'(1));
        check("t1_alu_and", DW'(alu_is_and), DW'(1));
        do_beat({DW{1'b1}}, {16{8'h0F}});
        check("t1_b0_valid", DW'(res_valid), DW'(1));
        check("t1_b0_data", res_data, {16{8'h0F}});
        check("t1_b0_last", DW'(res_last), DW'(0));
        do_beat({DW{1'b1}}, {16{8'h0F}});
        check("t1_b1_data", res_data, {16{8'h0F}});
        check("t1_b1_last", DW'(res_last), DW'(1));
        cycles(1);
        check("t1_busy_fall", DW'(busy), DW'(0));
        check("t1_count", DW'(q_data.size()), DW'(2));
        expect_res("t1_r0", {16{8'h0F}}, 1'b0);
        expect_res("t1_r1", {16{8'h0F}}, 1'b1);

        // xnor of equal operands gives all ones
        send_cmd(3'd2, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1);
        do_beat({8{16'h1234}}, {8{16'h1234}});
        cycles(2);
        check("t2_count", DW'(q_data.size()), DW'(1));
        expect_res("t2", {DW{1'b1}}, 1'b1);

        // or reduction, 32-bit elements, upper garbage must be masked off
        send_cmd(3'd1, 1'b1, 1'b0, 1'b0, 3'd2, 4'd4);
        check("t3_alu_reduct", DW'(alu_is_reduct), DW'(1));
        for (int k = 0; k < 4; k++) begin
            v = {32'hDEAD0000 + 32'(k), 64'h0000CAFE0000CAFE, 32'(1) << k};
            do_beat(v, v);
        end
        cycles(4);
        check("t3_count", DW'(q_data.size()), DW'(1));
        expect_res("t3", 128'h0F, 1'b1);
        check("t3_busy", DW'(busy), DW'(0));

        // xnor reduction on bytes: ~(0x3C ^ 0x0F) = 0xCC
        send_cmd(3'd2, 1'b1, 1'b0, 1'b1, 3'd0, 4'd2);
        check("t3b_alu_negres", DW'(alu_is_negate_result), DW'(0));
        do_beat({120'hFACE, 8'h3C}, '0);
        do_beat({120'hBEEF, 8'h0F}, '0);
        cycles(4);
        check("t3b_count", DW'(q_data.size()), DW'(1));
        expect_res("t3b", 128'hCC, 1'b1);

        // element-wise with a 3-cycle output stall
        send_cmd(3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd4);
        do_beat(128'h11, {DW{1'b1}});
        res_ready = 1'b0;
        fork
            begin
                do_beat(128'h22, {DW{1'b1}});
                do_beat(128'h33, {DW{1'b1}});
                do_beat(128'h44, {DW{1'b1}});
            end
            begin
                @(posedge clk);
                #1;
                check("t4_stall_beat_ready", DW'(beat_ready), DW'(0));
                check("t4_stall_hold", res_data, 128'h11);
                @(posedge clk);
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        cycles(3);
        check("t4_count", DW'(q_data.size()), DW'(4));
        expect_res("t4_r0", 128'h11, 1'b0);
        expect_res("t4_r1", 128'h22, 1'b0);
        expect_res("t4_r2", 128'h33, 1'b0);
        expect_res("t4_r3", 128'h44, 1'b1);

        // reserved op executes as plain and
        send_cmd(3'd7, 1'b0, 1'b1, 1'b1, 3'd0, 4'd1);
        check("t5_err", DW'(cmd_err), DW'(1));
        check("t5_alu_and", DW'(alu_is_and), DW'(1));
        check("t5_neg_a", DW'(alu_is_negate_srca), DW'(0));
        check("t5_neg_res", DW'(alu_is_negate_result), DW'(0));
        do_beat({16{8'hF0}}, {8{16'hFF00}});
        check("t5_err_end", DW'(cmd_err), DW'(0));
        // oversized element clamps to 128b
        send_cmd(3'd1, 1'b0, 1'b0, 1'b0, 3'd6, 4'd1);
        check("t5b_err", DW'(cmd_err), DW'(1));
        check("t5b_osize", DW'(alu_osize_vector), DW'(5'b10000));
        check("t5b_greater", DW'(alu_is_greater_osize_vector), DW'(5'b01111));
        do_beat(128'h5, 128'hA0);
        cycles(2);
        check("t5_count", DW'(q_data.size()), DW'(2));
        expect_res("t5_r0", {8{16'hF000}}, 1'b1);
        expect_res("t5_r1", 128'hA5, 1'b1);

        // sra ignores the reduction flag
        send_cmd(3'd5, 1'b1, 1'b0, 1'b0, 3'd3, 4'd1);
        check("t6_reduct", DW'(alu_is_reduct), DW'(0));
        check("t6_arith", DW'({alu_is_shift, alu_is_left, alu_is_arith}), DW'(3'b101));
        do_beat({4'h8, 124'h0}, 128'd4);
        cycles(2);
        expect_res("t6", {8'hF8, 120'h0}, 1'b1);

        // reset in the middle of a reduction
        send_cmd(3'd1, 1'b1, 1'b0, 1'b0, 3'd4, 4'd4);
        do_beat({DW{1'b1}}, {DW{1'b1}});
        do_beat(128'hFFFF0000, 128'hFFFF0000);
        rst_n = 1'b0;
        #1;
        check("t7_busy", DW'(busy), DW'(0));
        check("t7_cmd_ready", DW'(cmd_ready), DW'(1));
        check("t7_res_valid", DW'(res_valid), DW'(0));
        check("t7_alu_ctl", DW'(ctl_pack), DW'(0));
        #2;
        rst_n = 1'b1;
        cycles(1);
        q_data.delete();
        q_last.delete();
        send_cmd(3'd2, 1'b1, 1'b0, 1'b0, 3'd4, 4'd1);
        do_beat(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, '0);
        cycles(4);
        check("t7_count", DW'(q_data.size()), DW'(1));
        expect_res("t7", 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_v_logic_seq.md
Name: riscv_v_logic_seq

Overview:
- Sequencer and controller for the vector logic/shift ALU.
- Accepts one logic-class vector command, then streams one ALU beat per register of the LMUL group (1/2/4/8 beats).
- Drives the ALU control and operand inputs and registers each ALU result onto an output stream.
- For reductions (vredand/vredor/vredxor), combines the per-beat reduced values across the group and emits a single result.
- Sits between vector issue/operand-read and writeback.

Parameters:
- DATA_W, 128, vector register / ALU data width in bits (multiple of 64).
- NREGS_W, 4, width of the register-group count field.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command valid
- cmd_ready  output  1  command accepted when valid&ready
- cmd_op  input  3  0=and 1=or 2=xor 3=sll 4=srl 5=sra; 6,7 reserved
- cmd_reduct  input  1  reduction (ops 0-2 only)
- cmd_neg_a  input  1  invert srca before the op (andn/orn forms)
- cmd_neg_res  input  1  invert result (nand/nor/xnor)
- cmd_osize  input  3  element size: 0=8b 1=16b 2=32b 3=64b 4=128b
- cmd_nregs  input  NREGS_W  beats in group; 0 treated as 1
- beat_valid  input  1  operand beat valid
- beat_ready  output  1  operand beat accepted
- beat_srca  input  DATA_W  operand A
- beat_srcb  input  DATA_W  operand B
- alu_is_and, alu_is_or, alu_is_xor, alu_is_shift, alu_is_left, alu_is_arith, alu_is_reduct, alu_is_negate_srca, alu_is_negate_result  output  1 each  ALU controls
- alu_osize_vector  output  5  one-hot element size
- alu_is_greater_osize_vector  output  5  bit i set when osize > i
- alu_srca  output  DATA_W  ALU operand A
- alu_srcb  output  DATA_W  ALU operand B
- alu_result  input  DATA_W  combinational ALU result
- res_valid  output  1  result valid
- res_ready  input  1  result accepted
- res_data  output  DATA_W  result
- res_last  output  1  last result of the command
- busy  output  1  command in flight
- cmd_err  output  1  one-cycle pulse: reserved op or osize > 4 accepted

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - res_valid=0, res_last=0, res_data=0, busy=0, cmd_err=0, accumulator=0.
  - All alu_* controls = 0.
- States:
  - IDLE: cmd_ready=1.
  - RUN: cmd_ready=0.
  - RED_OUT: cmd_ready=0.
- IDLE → RUN on cmd handshake; latch op, flags and osize; beat counter = max(cmd_nregs,1); busy=1 from the next cycle.
- Reserved op: command is latched as and with both negate flags cleared, cmd_err pulses.
- osize > 4: clamped to 4, cmd_err pulses.
- cmd_reduct is ignored for shift ops.
- ALU controls are driven from latched state for the whole of RUN.
- alu_srca/alu_srcb pass beat_srca/beat_srcb through combinationally.
- Element-wise, RUN:
  - beat_ready = !res_valid | res_ready.
  - On a beat handshake, res_data <= alu_result and res_valid <= 1 on the next edge (1-cycle latency).
  - res_last=1 on the final beat; counter decrements.
  - After the final beat → IDLE.
  - res_valid holds until res_ready. Full throughput of 1 beat/cycle when res_ready=1.
- Reduction, RUN:
  - beat_ready=1.
  - First beat: acc <= alu_result.
  - Later beats: acc <= acc OP alu_result (OP = latched and/or/xor; negate_result applied once, at output only; ALU driven with alu_is_negate_result=0).
  - Final beat → RED_OUT.
- RED_OUT:
  - res_data = (final acc, optionally inverted) masked to the low element-size bits, upper bits 0.
  - res_valid=1, res_last=1; → IDLE on res_ready.
- Simultaneous events:
  - A new cmd is only accepted in IDLE; the IDLE cycle after the last element-wise beat accepts a new cmd even while res_valid is pending.
  - RUN of the next command stalls beats until res_valid clears.
- Reset mid-operation discards the command and the accumulator; no partial result is emitted.
- busy = (state != IDLE) | res_valid.

Test Plan:
- DATA_W=128, and, nregs=2, osize=0, A=0xFF..FF, B=0x0F..0F, res_ready=1 → two results 0x0F..0F one cycle after each beat; res_last on the second; busy falls after.
- xor, neg_res=1 (xnor), nregs=1, A=B=0x1234.. → res_data all-ones; res_last=1.
- Reduction or, osize=2, nregs=4; beats whose ALU-reduced lane-0 values are 0x1, 0x2, 0x4, 0x8 → single result 0x0000000F in bits[31:0], all other bits 0; res_last=1.
- Element-wise, nregs=4 with res_ready held 0 for 3 cycles after the first result → beat_ready=0 during the stall; no result lost or duplicated; 4 results in order.
- cmd_op=7, then cmd_osize=6 → cmd_err pulse each time; command executes as and / osize=4 (alu_osize_vector=5'b10000, alu_is_greater_osize_vector=5'b01111).
- rst_n low after beat 2 of a 4-beat reduction → outputs return to reset values immediately; a following nregs=1 command produces a correct, uncontaminated result.
